// File: rtl/controlador_memoria_dados_pkg.sv
// pacote_memoria: op codes, FSM states and RAM depth shared by the controller and the RAM
package pacote_memoria;
  localparam int MEM_WORDS = 2048;
  localparam logic [1:0] OP_LER = 2'b00;
  localparam logic [1:0] OP_ESCREVER = 2'b01;
  localparam logic [1:0] OP_BASE = 2'b10;
  typedef enum logic [2:0] {
    OCIOSO,
    ESCRITA,
    LEITURA_ENDERECO,
    LEITURA_CAPTURA,
    RESPOSTA
  } estado_t;
endpackage

// File: rtl/controlador_memoria_dados.sv
// controlador_memoria_dados: base-relative load/store/set-base controller in front of a registered-read RAM
module controlador_memoria_dados
  import pacote_memoria::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS = pacote_memoria::MEM_WORDS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_endereco,
  input  logic [DATA_WIDTH-1:0] req_dado,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_dado,
  output logic                  resp_erro,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_endereco_leitura,
  output logic [ADDR_WIDTH-1:0] ram_endereco_escrita,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);
  estado_t state_q, state_d;
  logic [DATA_WIDTH-1:0] base_q, base_d, resp_dado_q, resp_dado_d, ram_data_q, ram_data_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d, wr_q, wr_d, ea;
  logic we_q, we_d, valid_q, valid_d, erro_q, erro_d, aceita, falha;
  assign req_ready = state_q == OCIOSO && !reset;
  assign aceita = req_valid && req_ready;
  assign ea = ADDR_WIDTH'(base_q) + req_endereco;
  assign falha = req_op == 2'b11 || (req_op != OP_BASE && ea >= ADDR_WIDTH'(MEM_WORDS));
  assign resp_valid = valid_q;
  assign resp_dado = resp_dado_q;
  assign resp_erro = erro_q;
  assign ram_data = ram_data_q;
  assign ram_endereco_leitura = rd_q;
  assign ram_endereco_escrita = wr_q;
  assign ram_we = we_q;
  // next state and registered outputs; ram_we defaults low so it only pulses for one cycle
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    resp_dado_d = resp_dado_q;
    ram_data_d = ram_data_q;
    rd_d = rd_q;
    wr_d = wr_q;
    we_d = 1'b0;
    valid_d = valid_q;
    erro_d = erro_q;
    case (state_q)
      OCIOSO: if (aceita) begin
        if (falha || req_op == OP_BASE) begin
          base_d = falha ? base_q : req_dado;
          state_d = RESPOSTA;
          valid_d = 1'b1;
          erro_d = falha;
          resp_dado_d = '0;
        end else if (req_op == OP_ESCREVER) begin
          wr_d = ea;
          ram_data_d = req_dado;
          we_d = 1'b1;
          state_d = ESCRITA;
        end else begin
          rd_d = ea;
          state_d = LEITURA_ENDERECO;
        end
      end
      ESCRITA: begin
        state_d = RESPOSTA;
        valid_d = 1'b1;
        erro_d = 1'b0;
        resp_dado_d = '0;
      end
      LEITURA_ENDERECO: state_d = LEITURA_CAPTURA;
      LEITURA_CAPTURA: begin
        state_d = RESPOSTA;
        valid_d = 1'b1;
        erro_d = 1'b0;
        resp_dado_d = ram_q;
      end
      RESPOSTA: if (resp_ready) begin
        state_d = OCIOSO;
        valid_d = 1'b0;
      end
      default: state_d = OCIOSO;
    endcase
  end
  // state and output registers; reset drops any pending response and the write strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= OCIOSO;
      base_q <= '0;
      resp_dado_q <= '0;
      ram_data_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      we_q <= 1'b0;
      valid_q <= 1'b0;
      erro_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      resp_dado_q <= resp_dado_d;
      ram_data_q <= ram_data_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      we_q <= we_d;
      valid_q <= valid_d;
      erro_q <= erro_d;
    end
  end
endmodule
